// File: rtl/axi_tone_slave.sv
// AXI-lite style write-only register slave driving a square-wave tone generator.
// Registers: addr 0 = NOTE[6:0], addr 1 = CTRL (bit0 enable); other addresses answer SLVERR.
module axi_tone_slave #(
  parameter int unsigned PRESCALE = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] AWADDR,
  input  logic       AWVALID,
  output logic       AWREADY,
  input  logic [6:0] WDATA,
  input  logic       WVALID,
  output logic       WREADY,
  output logic       BVALID,
  input  logic       BREADY,
  output logic [1:0] BRESP,
  output logic       audio_out,
  output logic       note_active
);

  localparam int unsigned NOTE_W  = 7;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PROD_W  = NOTE_W + $clog2(PRESCALE + 1);
  localparam int unsigned HP_W    = (PROD_W > CNT_W) ? PROD_W : CNT_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  logic                aw_held;
  logic                w_held;
  logic [ADDR_W-1:0]   addr_q;
  logic [NOTE_W-1:0]   data_q;
  logic [NOTE_W-1:0]   note;
  logic                enable;
  logic [CNT_W-1:0]    tone_cnt;

  logic                aw_beat;
  logic                w_beat;
  logic                aw_next;
  logic                w_next;
  logic                running;
  logic                note_wr;
  logic [HP_W-1:0]     hp;
  logic [HP_W-1:0]     hp_last;

  // Handshake qualifiers, tone-run condition and half-period arithmetic
  always_comb begin
    aw_beat = AWVALID & AWREADY;
    w_beat  = WVALID & WREADY;
    aw_next = aw_held | aw_beat;
    w_next  = w_held | w_beat;
    running = enable && (note != '0);
    note_wr = (state == WRITE) && (addr_q == ADDR_W'(0));
    hp      = HP_W'(note) * HP_W'(PRESCALE);
    hp_last = hp - HP_W'(1);
  end

  // Write-channel FSM: collect AW and W in any order, commit once, hold response until BREADY
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= RESP_OKAY;
      note    <= '0;
      enable  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (aw_beat) addr_q <= AWADDR;
          if (w_beat)  data_q <= WDATA;
          aw_held <= aw_next;
          w_held  <= w_next;
          if (aw_next && w_next) begin
            state   <= WRITE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
          end else begin
            AWREADY <= !aw_next;
            WREADY  <= !w_next;
          end
        end
        WRITE: begin
          state  <= RESP;
          BVALID <= 1'b1;
          if (addr_q == ADDR_W'(0)) begin
            note  <= data_q;
            BRESP <= RESP_OKAY;
          end else if (addr_q == ADDR_W'(1)) begin
            enable <= data_q[0];
            BRESP  <= RESP_OKAY;
          end else begin
            BRESP <= RESP_SLVERR;
          end
        end
        RESP: begin
          if (BREADY) begin
            state   <= IDLE;
            BVALID  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tone counter: NOTE writes restart the phase; idle forces counter and output low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tone_cnt    <= '0;
      audio_out   <= 1'b0;
      note_active <= 1'b0;
    end else begin
      note_active <= running;
      if (note_wr || !running) begin
        tone_cnt  <= '0;
        audio_out <= 1'b0;
      end else if (HP_W'(tone_cnt) == hp_last) begin
        tone_cnt  <= '0;
        audio_out <= ~audio_out;
      end else begin
        tone_cnt <= tone_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/axi_tone_slave.md
AXI_TONE_SLAVE -- requirements
Module: axi_tone_slave

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 256, meaning the clk cycles per note-code unit of tone half-period.
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port AWADDR  input  4  write address (register index).
REQ-005 The block SHALL have port AWVALID  input  1  address valid from master.
REQ-006 The block SHALL have port AWREADY  output  1  address accept, registered.
REQ-007 The block SHALL have port WDATA  input  7  write data.
REQ-008 The block SHALL have port WVALID  input  1  data valid from master.
REQ-009 The block SHALL have port WREADY  output  1  data accept, registered.
REQ-010 The block SHALL have port BVALID  output  1  write response valid, registered.
REQ-011 The block SHALL have port BREADY  input  1  response accept from master.
REQ-012 The block SHALL have port BRESP  output  2  response code: 2'b00 OKAY, 2'b10 SLVERR.
REQ-013 The block SHALL have port audio_out  output  1  square-wave tone output.
REQ-014 The block SHALL have port note_active  output  1  high while a tone is being generated.

Function
REQ-015 Register map SHALL be: addr 0 NOTE[6:0]; addr 1 CTRL, bit0 = enable, bits 6:1 ignored; addr 2..15 unmapped.
REQ-016 Handshake FSM SHALL have states IDLE, WRITE and RESP.
REQ-017 In IDLE, AWREADY SHALL be high while no address is held, and WREADY SHALL be high while no data is held.
REQ-018 An AW beat (AWVALID & AWREADY at an edge) SHALL latch AWADDR and set aw_held; AWREADY SHALL be low from the next cycle.
REQ-019 A W beat SHALL latch WDATA and set w_held in the same way; AW and W SHALL be accepted in either order or on the same edge.
REQ-020 When aw_held and w_held are both set, the FSM SHALL enter WRITE for exactly one cycle, with AWREADY and WREADY low.
REQ-021 On the edge leaving WRITE, the addressed register SHALL update.
REQ-022 On that same edge, BVALID SHALL be set with BRESP 00 for addr 0/1, or BRESP 10 and no state change for addr 2..15, and the FSM SHALL enter RESP.
REQ-023 Latency: with both beats on edge k, the register update and BVALID rise SHALL occur at edge k+1.
REQ-024 In RESP, BVALID and BRESP SHALL hold stable until BREADY is sampled high.
REQ-025 On the BREADY handshake edge, BVALID SHALL clear, held flags SHALL clear, and the FSM SHALL return to IDLE; AWREADY and WREADY SHALL be high from the following cycle.
REQ-026 AWVALID or WVALID asserted while the corresponding ready is low SHALL be ignored, with no latching and no error.
REQ-027 Tone generation SHALL run only when enable=1 and NOTE!=0; half-period HP = NOTE*PRESCALE clk cycles, computed at 16 bits minimum with no truncation.
REQ-028 A 16-bit tone_cnt SHALL increment every cycle while running; at tone_cnt == HP-1 it SHALL wrap to 0 and audio_out SHALL toggle.
REQ-029 When not running, tone_cnt SHALL be held at 0 and audio_out SHALL be forced to 0 from the next edge.
REQ-030 Any OKAY write to NOTE, including rewriting the same value, SHALL reset tone_cnt to 0 and audio_out to 0 on the write edge (phase restart).
REQ-031 note_active SHALL be the registered value of (enable && NOTE!=0), updated one edge after the register change.

Reset
REQ-032 While reset is high, outputs SHALL be AWREADY=0, WREADY=0, BVALID=0, BRESP=00, audio_out=0 and note_active=0; internal state SHALL be NOTE=0, enable=1, tone_cnt=0, FSM=IDLE, held flags cleared.
REQ-033 Reset asserted mid-transaction (WRITE or RESP) SHALL discard the pending write and drop BVALID immediately.
REQ-034 AWREADY and WREADY SHALL first go high at the first rising edge after reset deasserts.

Verification
REQ-035 PRESCALE=4; AW(addr0) and W(3) on the same edge k with BREADY=1 -> BVALID=1/BRESP=00 at k+1, note_active=1 at k+2, audio_out toggles every 12 cycles.
REQ-036 W(5) at edge k, then AW(addr0) at edge k+3 -> WREADY low from k+1 while AWREADY stays high until k+3, NOTE=5 at k+4, exactly one BVALID pulse.
REQ-037 BREADY held low for 6 cycles after BVALID -> BVALID and BRESP stable throughout, AWREADY=WREADY=0, and a new AWVALID is not accepted until the cycle after the BREADY handshake.
REQ-038 Write addr 7 with data 0x55 -> BRESP=10, NOTE and CTRL unchanged, tone phase undisturbed.
REQ-039 While running, write CTRL=0 -> audio_out=0 and note_active=0 within 2 edges; then write CTRL=1 -> tone restarts from tone_cnt 0.
REQ-040 Assert reset while in RESP with BVALID=1 -> BVALID=0 immediately, NOTE unchanged by the discarded write, AWREADY=1 at the first edge after release.
